chan_master: RTL and testbench
==============================

// Module: chan_master
// PURPOSE
//  Initiator side of the FPGALink channel interface: drives chanAddr/h2f and consumes f2h.
//  Executes framed commands from a byte stream against channel logic such as swled.
//  Write commands forward payload bytes to the h2f pipe.
//  Read commands return f2h bytes on a response byte stream.
//  Used as a comm-core stand-in and as an on-chip channel exerciser.
// PARAMETERS
//  LEN_BYTES  2  number of big-endian length bytes following each header (1..4)
// PORTS
//  clk_in        in   1   system clock; all state changes on rising edge
//  reset_in      in   1   asynchronous, active-low reset
//  cmdData_in    in   8   command/payload byte stream
//  cmdValid_in   in   1   cmdData_in valid
//  cmdReady_out  out  1   block accepts cmdData_in this cycle
//  rspData_out   out  8   read-data byte stream
//  rspValid_out  out  1   rspData_out valid
//  rspReady_in   in   1   downstream accepts rspData_out
//  chanAddr_out  out  7   selected channel
//  h2fData_out   out  8   write data to channel logic
//  h2fValid_out  out  1   write byte valid
//  h2fReady_in   in   1   channel logic accepts write byte
//  f2hData_in    in   8   read data from channel logic
//  f2hValid_in   in   1   read byte valid
//  f2hReady_out  out  1   block requests/accepts read byte
//  busy_out      out  1   1 when state != S_IDLE
//  done_out      out  1   one-cycle pulse after the final byte of a transfer
// BEHAVIOUR
//  - Transfer rules: a byte moves on a rising edge where valid & ready, on every stream.
//  - Reset (reset_in=0, async) forces:
//    - state=S_IDLE, count=0, chanAddr_out=0, lenIdx=0, done_out=0.
//    - All valid/ready outputs are 0 while reset is held; no partial transfer survives.
//  - Framing: header byte, then LEN_BYTES length bytes (MSB first), then payload.
//    - Header: bit7=1 means read, bit7=0 means write; bits6:0 give the channel.
//  - Registers: count is 8*LEN_BYTES bits wide; lenIdx counts length bytes received.
//  - S_IDLE: cmdReady_out=1.
//    - On accepted byte: chanAddr_out<=hdr[6:0], dir<=hdr[7], count<=0, go to S_LEN.
//  - S_LEN: cmdReady_out=1.
//    - Each accepted byte: count<={count[..-8],byte}, lenIdx++.
//    - On the last length byte, if the assembled length is 0: go to S_IDLE and pulse done_out.
//    - Otherwise go to S_WRITE (dir=0) or S_READ (dir=1).
//  - S_WRITE: combinational pass-through, zero latency.
//    - h2fData_out=cmdData_in; h2fValid_out=cmdValid_in; cmdReady_out=h2fReady_in.
//    - Each transfer decrements count; when count==1 and a transfer occurs, go to S_IDLE.
//  - S_READ: combinational pass-through, zero latency.
//    - rspData_out=f2hData_in; rspValid_out=f2hValid_in; f2hReady_out=rspReady_in.
//    - cmdReady_out=0, so the command stream stalls until the read completes.
//    - Decrement and termination rules are the same as S_WRITE.
//  - Outside their active state:
//    - h2fValid_out=0, f2hReady_out=0, rspValid_out=0; h2fData_out=0, rspData_out=0.
//  - chanAddr_out: held stable from header acceptance until the next header is accepted.
//  - done_out: registered; high for exactly 1 cycle in the cycle after the final payload transfer.
//    - For a zero-length command, it pulses in the cycle after the final length byte.
//  - Back-to-back commands: a header is accepted in the first S_IDLE cycle after done.
//    - No idle bubble beyond that single S_IDLE cycle.
//  - Stalls: any number of cycles with valid or ready low hold all state; no timeout.
//  - Maximum length: 2^(8*LEN_BYTES)-1; there is no wrap, since length 0 means empty.
// TESTING
//  1. Write, no backpressure.
//     - Stimulus: cmd 00,00,03,11,22,33 with h2fReady_in=1.
//     - Required: chanAddr_out=0; h2f carries 11,22,33 on 3 consecutive cycles.
//     - Required: done_out pulses once; with swled attached, checksum reads 0x0066.
//  2. Read.
//     - Stimulus: cmd 81,00,02 against swled with checksum=0x1234.
//     - Required: rsp carries 12 then... rspData_out=12; repeat read of ch2 gives 34.
//     - Required: busy_out drops after done_out.
//  3. Zero length.
//     - Stimulus: cmd 05,00,00.
//     - Required: no h2f activity; done_out pulses; chanAddr_out=5; the next header is accepted.
//  4. Backpressure.
//     - Stimulus: write of 4 bytes with h2fReady_in toggling 1,0,0,1,...
//     - Required: cmdReady_out mirrors h2fReady_in; exactly 4 bytes are delivered, in order.
//  5. Reset mid-operation.
//     - Stimulus: assert reset_in=0 after 2 of 5 write bytes; release it.
//     - Required: all outputs are 0 immediately; state is S_IDLE.
//     - Required: the next byte is treated as a header.
//  6. Back-to-back commands.
//     - Stimulus: a write of 1 byte to ch1, followed at once by a read of 1 byte from ch1.
//     - Required: ch1 reads back the written value; exactly 2 done_out pulses.

Source files
------------

// File: rtl/chan_master.sv
// -----------------------------------------------------------------------------
// chan_master
// Initiator side of an FPGALink-style channel interface. It consumes a framed
// command byte stream (header, big-endian length, payload) and executes each
// command against channel logic:
//   - write commands forward payload bytes onto the h2f pipe
//   - read commands return f2h bytes on the response stream
// Header bit7 selects read (1) / write (0); bits 6:0 select the channel.
//
// Ports
//   clk_in        system clock, rising edge
//   reset_in      asynchronous active-low reset
//   cmdData_in    command/payload byte      cmdValid_in / cmdReady_out handshake
//   rspData_out   read-data byte            rspValid_out / rspReady_in handshake
//   chanAddr_out  channel selected by the most recent header
//   h2fData_out   write byte to channel     h2fValid_out / h2fReady_in handshake
//   f2hData_in    read byte from channel    f2hValid_in / f2hReady_out handshake
//   busy_out      high whenever a command is in progress
//   done_out      one-cycle pulse after the final byte of a command
// -----------------------------------------------------------------------------
module chan_master #(
  parameter int LEN_BYTES = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] cmdData_in,
  input  logic       cmdValid_in,
  output logic       cmdReady_out,
  output logic [7:0] rspData_out,
  output logic       rspValid_out,
  input  logic       rspReady_in,
  output logic [6:0] chanAddr_out,
  output logic [7:0] h2fData_out,
  output logic       h2fValid_out,
  input  logic       h2fReady_in,
  input  logic [7:0] f2hData_in,
  input  logic       f2hValid_in,
  output logic       f2hReady_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int CW = 8 * LEN_BYTES;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEN   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [2:0]      len_idx_r;
  logic            dir_r;
  logic [6:0]      chan_r;
  logic            done_r;

  logic            cmd_ready_s;
  logic [7:0]      h2f_data_s;
  logic            h2f_valid_s;
  logic [7:0]      rsp_data_s;
  logic            rsp_valid_s;
  logic            f2h_ready_s;
  logic            xfer_s;
  logic [CW-1:0]   len_shift_s;
  logic            last_len_s;

  // Length assembly: shift the new byte in at the bottom, oldest byte falls off the top.
  assign len_shift_s = CW'({count_r, cmdData_in});
  assign last_len_s  = (len_idx_r == 3'(LEN_BYTES - 1));

  // Per-state handshake routing; payload phases are zero-latency pass-throughs.
  always_comb begin
    cmd_ready_s = 1'b0;
    h2f_data_s  = 8'h00;
    h2f_valid_s = 1'b0;
    rsp_data_s  = 8'h00;
    rsp_valid_s = 1'b0;
    f2h_ready_s = 1'b0;
    xfer_s      = 1'b0;
    case (state_r)
      S_IDLE, S_LEN: begin
        // Gated by reset_in so no ready is advertised while reset is held.
        cmd_ready_s = reset_in;
        xfer_s      = cmdValid_in & reset_in;
      end
      S_WRITE: begin
        h2f_data_s  = cmdData_in;
        h2f_valid_s = cmdValid_in;
        cmd_ready_s = h2fReady_in;
        xfer_s      = cmdValid_in & h2fReady_in;
      end
      S_READ: begin
        // Command stream stays stalled (cmd_ready_s=0) until the read completes.
        rsp_data_s  = f2hData_in;
        rsp_valid_s = f2hValid_in;
        f2h_ready_s = rspReady_in;
        xfer_s      = f2hValid_in & rspReady_in;
      end
      default: begin
        cmd_ready_s = 1'b0;
      end
    endcase
  end

  // Command sequencer: header capture, length assembly, payload countdown.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r   <= S_IDLE;
      count_r   <= '0;
      len_idx_r <= 3'd0;
      dir_r     <= 1'b0;
      chan_r    <= 7'd0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (xfer_s) begin
            chan_r    <= cmdData_in[6:0];
            dir_r     <= cmdData_in[7];
            count_r   <= '0;
            len_idx_r <= 3'd0;
            state_r   <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer_s) begin
            count_r   <= len_shift_s;
            len_idx_r <= len_idx_r + 3'd1;
            if (last_len_s) begin
              if (len_shift_s == '0) begin
                // Empty command: finish straight from the length phase.
                state_r <= S_IDLE;
                done_r  <= 1'b1;
              end else if (dir_r) begin
                state_r <= S_READ;
              end else begin
                state_r <= S_WRITE;
              end
            end
          end
        end
        S_WRITE, S_READ: begin
          if (xfer_s) begin
            count_r <= count_r - CW'(1);
            if (count_r == CW'(1)) begin
              state_r <= S_IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign cmdReady_out = cmd_ready_s;
  assign h2fData_out  = h2f_data_s;
  assign h2fValid_out = h2f_valid_s;
  assign rspData_out  = rsp_data_s;
  assign rspValid_out = rsp_valid_s;
  assign f2hReady_out = f2h_ready_s;
  assign chanAddr_out = chan_r;
  assign busy_out     = (state_r != S_IDLE);
  assign done_out     = done_r;

endmodule

// File: tb/tb_chan_master.sv
// -----------------------------------------------------------------------------
// tb_chan_master
// Directed bench for chan_master. A small channel model (128 byte registers)
// sits on the h2f/f2h side: writes land in the register of the addressed
// channel, reads return it. Inputs are driven on the falling edge and outputs
// are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_chan_master;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] cmdData_in;
  logic       cmdValid_in;
  logic       cmdReady_out;
  logic [7:0] rspData_out;
  logic       rspValid_out;
  logic       rspReady_in;
  logic [6:0] chanAddr_out;
  logic [7:0] h2fData_out;
  logic       h2fValid_out;
  logic       h2fReady_in;
  logic [7:0] f2hData_in;
  logic       f2hValid_in;
  logic       f2hReady_out;
  logic       busy_out;
  logic       done_out;

  chan_master #(.LEN_BYTES(2)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .cmdData_in   (cmdData_in),
    .cmdValid_in  (cmdValid_in),
    .cmdReady_out (cmdReady_out),
    .rspData_out  (rspData_out),
    .rspValid_out (rspValid_out),
    .rspReady_in  (rspReady_in),
    .chanAddr_out (chanAddr_out),
    .h2fData_out  (h2fData_out),
    .h2fValid_out (h2fValid_out),
    .h2fReady_in  (h2fReady_in),
    .f2hData_in   (f2hData_in),
    .f2hValid_in  (f2hValid_in),
    .f2hReady_out (f2hReady_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  // Clock generation.
  always #5 clk_in = ~clk_in;

  // Channel model state.
  logic [7:0]  mem [0:127];
  logic        preload;
  logic [14:0] h2f_q [$];
  int          done_cnt = 0;

  assign f2hData_in = mem[chanAddr_out];

  // Channel model: preload read values, then record every h2f transfer.
  always @(posedge clk_in) begin
    if (preload) begin
      mem[1] <= 8'h12;
      mem[2] <= 8'h34;
    end else if (h2fValid_out && h2fReady_in) begin
      mem[chanAddr_out] <= h2fData_out;
      h2f_q.push_back({chanAddr_out, h2fData_out});
    end
  end

  // Count done pulses.
  always @(negedge clk_in) begin
    if (done_out) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic cv, input logic [7:0] cd, input logic hr,
                      input logic rr, input logic fv);
    @(negedge clk_in);
    cmdValid_in = cv;
    cmdData_in  = cd;
    h2fReady_in = hr;
    rspReady_in = rr;
    f2hValid_in = fv;
    #1;
  endtask

  // {cmdReady, h2fValid, h2fData, rspValid, rspData, f2hReady, busy, done, chanAddr}
  function automatic logic [28:0] outs();
    return {cmdReady_out, h2fValid_out, h2fData_out, rspValid_out, rspData_out,
            f2hReady_out, busy_out, done_out, chanAddr_out};
  endfunction

  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic       hr;
    logic       rr;
    logic       fv;
    logic [28:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [7:0] cd, input logic hr,
                              input logic rr, input logic fv,
                              input logic e_cr, input logic e_hv, input logic [7:0] e_hd,
                              input logic e_rv, input logic [7:0] e_rd, input logic e_fr,
                              input logic e_busy, input logic e_done, input logic [6:0] e_chan);
    vec_t v;
    v.cv = cv; v.cd = cd; v.hr = hr; v.rr = rr; v.fv = fv;
    v.exp = {e_cr, e_hv, e_hd, e_rv, e_rd, e_fr, e_busy, e_done, e_chan};
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    int base;
    int idx;
    int cyc;
    int d0;
    logic hr;
    logic [7:0] bp_pay [4];
    bp_pay[0] = 8'hA1; bp_pay[1] = 8'hA2; bp_pay[2] = 8'hA3; bp_pay[3] = 8'hA4;

    // Write 00,00,03,11,22,33 to ch0.
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0));
    tbl.push_back(mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0));
    tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0));
    tbl.push_back(mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0));
    tbl.push_back(mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0));
    // Zero-length command 05,00,00 immediately after (done visible in first idle cycle).
    tbl.push_back(mk(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd5));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd5));
    // Read 81,00,02 from ch1 (model holds 0x12), with f2h/rsp stalls.
    tbl.push_back(mk(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd5));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 7'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd1));
    // Read 82,00,01 from ch2 (model holds 0x34).
    tbl.push_back(mk(1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd2));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 7'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2));

    // Reset with live inputs: every output must be 0.
    reset_in = 1'b0; preload = 1'b1;
    cmdValid_in = 1'b1; cmdData_in = 8'h81; h2fReady_in = 1'b1;
    rspReady_in = 1'b1; f2hValid_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    chk("reset_outputs", 32'(outs()), 32'h0);
    @(negedge clk_in);
    reset_in = 1'b0; preload = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_in = 1'b1;

    // Table: write, zero-length, reads.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cv, tbl[i].cd, tbl[i].hr, tbl[i].rr, tbl[i].fv);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    chk("write_h2f_count", 32'(h2f_q.size()), 32'd3);
    if (h2f_q.size() >= 3) begin
      chk("write_h2f_bytes", {8'h00, h2f_q[0][7:0], h2f_q[1][7:0], h2f_q[2][7:0]}, 32'h00112233);
    end

    // Backpressure: 4-byte write to ch3, h2fReady pattern 1,0,0,1 repeating.
    base = h2f_q.size();
    step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      hr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      step(1'b1, bp_pay[idx], hr, 1'b0, 1'b0);
      chk("bp_ready_mirror", {31'd0, cmdReady_out}, {31'd0, hr});
      chk("bp_h2f_valid", {31'd0, h2fValid_out}, 32'd1);
      if (hr) idx++;
      cyc++;
    end
    chk("bp_bytes_offered", 32'(idx), 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bp_done", {30'd0, done_out, busy_out}, 32'h2);
    chk("bp_h2f_count", 32'(h2f_q.size() - base), 32'd4);
    if (h2f_q.size() - base == 4) begin
      chk("bp_h2f_bytes", {h2f_q[base][7:0], h2f_q[base+1][7:0], h2f_q[base+2][7:0], h2f_q[base+3][7:0]}, 32'hA1A2A3A4);
      chk("bp_h2f_chan", 32'(h2f_q[base+3][14:8]), 32'd3);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset mid-write: 5-byte write to ch4, reset after 2 payload bytes.
    base = h2f_q.size();
    step(1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    @(negedge clk_in);
    reset_in = 1'b0; cmdData_in = 8'hD3; rspReady_in = 1'b1; f2hValid_in = 1'b1;
    #1;
    chk("midrst_outputs", 32'(outs()), 32'h0);
    @(negedge clk_in);
    reset_in = 1'b1; cmdValid_in = 1'b1; cmdData_in = 8'h07;
    rspReady_in = 1'b0; f2hValid_in = 1'b0;
    #1;
    chk("midrst_idle", 32'(outs()), 32'h10000000);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("midrst_hdr_chan", {24'd0, busy_out, chanAddr_out}, {24'd0, 1'b1, 7'd7});
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst_zero_done", {30'd0, done_out, busy_out}, 32'h2);
    chk("midrst_h2f_count", 32'(h2f_q.size() - base), 32'd2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-to-back: write 0x5C to ch1, then immediately read ch1.
    d0 = done_cnt;
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    chk("b2b_hdr_ready", {30'd0, cmdReady_out, done_out}, 32'h3);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("b2b_no_bubble", {31'd0, busy_out}, 32'd1);
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("b2b_readback", {16'd0, rspValid_out, chanAddr_out, rspData_out}, {16'd0, 1'b1, 7'd1, 8'h5C});
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("b2b_final_done", {30'd0, done_out, busy_out}, 32'h2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
